uart_rx_frame: RTL and testbench

- UART receiver that recovers the serial line driven by the design's uart_tx stage.
- Frame format: 1 start bit, DATA_WIDTH data bits LSB first, optional even parity bit, 1 stop bit.
- Emits the received byte with a one-cycle data_ready strobe plus error flags, for consumption by the LED/display stage.
- Sits directly downstream of uart_tx on the transmitted_signal wire.

---
 rtl/uart_rx_frame.sv | 143 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: serial receiver for the uart_tx line.
// 1 start, DATA_WIDTH data LSB first, optional even parity, 1 stop.
module uart_rx_frame #(
  parameter int BAUD_RATE  = 4800,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 27_000_000,
  parameter int PARITY_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  recieved_signal,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_ready,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int IW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_END  = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic                  sync1;
  logic                  sync;
  logic                  prev;
  logic                  fall;
  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic                  stop_bad;
  logic                  fin;

  assign fall = prev & ~sync;
  assign busy = (state != IDLE);

  // Two-flop synchroniser plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync  <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= recieved_signal;
      sync  <= sync1;
      prev  <= sync;
    end
  end

  // Frame sequencer: mid-bit sampling, then publish word and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      stop_bad     <= 1'b0;
      fin          <= 1'b0;
      data         <= '0;
      data_ready   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            if (sync) begin
              state <= IDLE;
            end else begin
              cnt   <= '0;
              idx   <= '0;
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_END) begin
            cnt   <= '0;
            shreg <= {sync, shreg[DATA_WIDTH-1:1]};
            idx   <= idx + IW'(1);
            if (idx == IDX_END) begin
              state <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          if (cnt == CNT_END) begin
            cnt     <= '0;
            par_bit <= sync;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (fin) begin
            fin          <= 1'b0;
            cnt          <= '0;
            data         <= shreg;
            frame_error  <= stop_bad;
            data_ready   <= 1'b1;
            parity_error <= (PARITY_EN != 0) ? (^shreg ^ par_bit) : 1'b0;
            // An edge right after the stop sample starts the next frame.
            state        <= fall ? START : IDLE;
          end else if (cnt == CNT_END) begin
            stop_bad <= ~sync;
            fin      <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: table vectors plus scoreboard
// for uart_rx_frame with 16 clocks per bit.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line = 1'b1;
  logic [7:0] data;
  logic       data_ready;
  logic       parity_error;
  logic       frame_error;
  logic       busy;

  uart_rx_frame #(
    .BAUD_RATE (1),
    .DATA_WIDTH(8),
    .CLK_FREQ  (16),
    .PARITY_EN (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .recieved_signal(line),
    .data           (data),
    .data_ready     (data_ready),
    .parity_error   (parity_error),
    .frame_error    (frame_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       pbit;
    logic       sbit;
    logic       pe;
    logic       fe;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int npulse = 0;
  int fall_cyc = 0;
  int last_pulse = 0;
  int prev_pulse = 0;
  int base;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every data_ready pops one expected frame.
  always @(posedge clk) begin
    #1;
    if (data_ready) begin
      npulse++;
      prev_pulse = last_pulse;
      last_pulse = cyc;
      check("ready_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("data", data, mon_e.d);
        check("parity_error", parity_error, mon_e.pe);
        check("frame_error", frame_error, mon_e.fe);
        check("busy_low_at_ready", busy, 0);
        check("latency_171pm1",
              ((cyc - fall_cyc - 1) >= 170) &&
              ((cyc - fall_cyc - 1) <= 172), 1);
      end
    end
  end

  task automatic push(input logic [7:0] d,
                      input logic pe,
                      input logic fe);
    exp_t e;
    e.d = d;
    e.pe = pe;
    e.fe = fe;
    sb.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    line = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic pb,
                            input logic st);
    line = 1'b0;
    fall_cyc = cyc;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pb);
    drive_bit(st);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_pe", parity_error, 0);
    check("rst_fe", frame_error, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", data_ready, 0);
    check("rst_pulses", npulse, 0);

    for (int i = 0; i < 3; i++) begin
      push(vecs[i].d, vecs[i].pe, vecs[i].fe);
      send_frame(vecs[i].d, vecs[i].pbit, vecs[i].sbit);
      line = 1'b1;
      repeat (32) @(negedge clk);
      drain();
    end
    check("table_pulses", npulse, 3);

    push(8'hFF, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    line = 1'b1;
    repeat (32) @(negedge clk);
    drain();
    check("break_no_spurious", npulse, 4);
    check("break_busy", busy, 0);

    push(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    line = 1'b1;
    repeat (32) @(negedge clk);
    drain();

    line = 1'b0;
    repeat (4) @(negedge clk);
    line = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_pulses", npulse, 5);
    check("glitch_data", data, 8'h55);
    check("glitch_pe", parity_error, 0);
    check("glitch_fe", frame_error, 0);
    check("glitch_busy", busy, 0);

    push(8'h12, 1'b0, 1'b0);
    push(8'h34, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    line = 1'b1;
    repeat (32) @(negedge clk);
    drain();
    check("b2b_pulses", npulse, 7);
    check("b2b_spacing", last_pulse - prev_pulse, 176);

    base = npulse;
    line = 1'b0;
    fall_cyc = cyc;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    line = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_frame_busy", busy, 1);
    rst = 1'b1;
    line = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data", data, 0);
    check("midrst_pe", parity_error, 0);
    check("midrst_fe", frame_error, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", data_ready, 0);
    repeat (200) @(negedge clk);
    check("midrst_no_pulse", npulse, base);

    push(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    line = 1'b1;
    repeat (32) @(negedge clk);
    drain();
    check("after_rst_pulse", npulse, base + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
